// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: seq_op encoding and the reset vector.
package useq_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT    = 3'd0,
    SEQ_JUMP    = 3'd1,
    SEQ_MAP     = 3'd2,
    SEQ_BRT     = 3'd3,
    SEQ_CALL    = 3'd4,
    SEQ_RET     = 3'd5,
    SEQ_HOLD    = 3'd6,
    SEQ_RESTART = 3'd7
  } seq_op_e;

  localparam int RESET_VEC = 0;

endpackage

// File: rtl/useq_stack.sv
// Return-address stack for the microsequencer. Pointer is reset; entry storage is not.
module useq_stack
  import useq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int UA_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clr,
  input  logic [UA_W-1:0] push_data,
  output logic [UA_W-1:0] top_data,
  output logic            full,
  output logic            empty
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [UA_W-1:0] mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - SP_W'(1);
  // sp points at the next free slot, so the top entry sits one below it.
  assign top_data = mem[sp_dec[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/useq.sv
// Microprogram sequencer: registered upc with next-address mux and optional return stack.
// The return stack and sticky err flag exist only when USEQ_STACK_EN is defined.
module useq
  import useq_pkg::*;
#(
  parameter int UA_W  = 8,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4,
  parameter int NCOND = 4,
  localparam int CS_W = (NCOND > 1) ? $clog2(NCOND) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      seq_op,
  input  logic [UA_W-1:0] jump_addr,
  input  logic [OP_W-1:0] ir_op,
  input  logic [CS_W-1:0] cond_sel,
  input  logic [NCOND-1:0] cond_in,
  input  logic            stall,
  input  logic            clr_err,
  output logic [UA_W-1:0] upc,
  output logic            stk_full,
  output logic            stk_empty,
  output logic            err
);

  seq_op_e         op;
  logic [UA_W-1:0] upc_inc;
  logic [UA_W-1:0] map_addr;
  logic [UA_W-1:0] upc_nxt;
  logic            cond_true;

  assign op       = seq_op_e'(seq_op);
  assign upc_inc  = upc + UA_W'(1);
  assign map_addr = UA_W'(ir_op) << (UA_W - OP_W);

  // Selects outside 0..NCOND-1 never match, so they read as false.
  always_comb begin
    cond_true = 1'b0;
    for (int i = 0; i < NCOND; i++) begin
      if (cond_sel == i[CS_W-1:0]) cond_true = cond_in[i];
    end
  end

`ifdef USEQ_STACK_EN
  logic            push;
  logic            pop;
  logic            stk_clr;
  logic            err_set;
  logic [UA_W-1:0] stk_top;
`endif

  always_comb begin
    upc_nxt = upc;
`ifdef USEQ_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    stk_clr = 1'b0;
    err_set = 1'b0;
`endif
    case (op)
      SEQ_NEXT: upc_nxt = upc_inc;
      SEQ_JUMP: upc_nxt = jump_addr;
      SEQ_MAP:  upc_nxt = map_addr;
      SEQ_BRT:  upc_nxt = cond_true ? jump_addr : upc_inc;
`ifdef USEQ_STACK_EN
      SEQ_CALL: begin
        if (stk_full) begin
          upc_nxt = upc_inc;
          err_set = 1'b1;
        end else begin
          upc_nxt = jump_addr;
          push    = 1'b1;
        end
      end
      SEQ_RET: begin
        if (stk_empty) begin
          upc_nxt = UA_W'(RESET_VEC);
          err_set = 1'b1;
        end else begin
          upc_nxt = stk_top;
          pop     = 1'b1;
        end
      end
      SEQ_RESTART: begin
        upc_nxt = UA_W'(RESET_VEC);
        stk_clr = 1'b1;
      end
`else
      SEQ_CALL:    upc_nxt = jump_addr;
      SEQ_RET:     upc_nxt = upc_inc;
      SEQ_RESTART: upc_nxt = UA_W'(RESET_VEC);
`endif
      default:  upc_nxt = upc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upc <= UA_W'(RESET_VEC);
    end else if (!stall) begin
      upc <= upc_nxt;
    end
  end

`ifdef USEQ_STACK_EN
  useq_stack #(
    .DEPTH (DEPTH),
    .UA_W  (UA_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push && !stall),
    .pop       (pop && !stall),
    .clr       (stk_clr && !stall),
    .push_data (upc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // A new error in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (!stall) begin
      if (err_set) err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_useq.sv
// Directed bench for useq; expectations follow whether USEQ_STACK_EN is defined.
module tb_useq;
  import useq_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] seq_op;
  logic [7:0] jump_addr;
  logic [3:0] ir_op;
  logic [1:0] cond_sel;
  logic [3:0] cond_in;
  logic       stall;
  logic       clr_err;
  logic [7:0] upc;
  logic       stk_full;
  logic       stk_empty;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_upc;
  logic [7:0] exp_q[$];

  useq #(.UA_W(8), .OP_W(4), .DEPTH(4), .NCOND(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seq_op    (seq_op),
    .jump_addr (jump_addr),
    .ir_op     (ir_op),
    .cond_sel  (cond_sel),
    .cond_in   (cond_in),
    .stall     (stall),
    .clr_err   (clr_err),
    .upc       (upc),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err       (err)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one op, let one edge pass, sample 1 time unit after it.
  task automatic step(input logic [2:0] op, input logic [7:0] ja);
    seq_op    = op;
    jump_addr = ja;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; seq_op = SEQ_HOLD; jump_addr = '0; ir_op = '0;
    cond_sel = '0; cond_in = '0; stall = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upc", upc, 8'h00);
    chk("rst_empty", stk_empty, 1'b1);
    chk("rst_full", stk_full, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;

    step(SEQ_NEXT, 8'h00); chk("next1", upc, 8'h01);
    step(SEQ_NEXT, 8'h00); chk("next2", upc, 8'h02);
    step(SEQ_NEXT, 8'h00); chk("next3", upc, 8'h03);
    step(SEQ_JUMP, 8'hFF); chk("jump_ff", upc, 8'hFF);
    step(SEQ_NEXT, 8'h00); chk("next_wrap", upc, 8'h00);
    step(SEQ_HOLD, 8'h55); chk("hold", upc, 8'h00);

    ir_op = 4'hA;
    step(SEQ_MAP, 8'h00); chk("map", upc, 8'hA0);
    cond_in = 4'b0100; cond_sel = 2'd2;
    step(SEQ_BRT, 8'h40); chk("brt_taken", upc, 8'h40);
    cond_sel = 2'd1;
    step(SEQ_BRT, 8'h90); chk("brt_not_taken", upc, 8'h41);
    step(SEQ_RESTART, 8'h33); chk("restart", upc, 8'h00);

    step(SEQ_JUMP, 8'h10);
    step(SEQ_CALL, 8'h80); chk("call_upc", upc, 8'h80);
`ifdef USEQ_STACK_EN
    chk("call_empty", stk_empty, 1'b0);
    step(SEQ_RET, 8'h00); chk("ret_upc", upc, 8'h11);
    chk("ret_empty", stk_empty, 1'b1);

    // nested calls: expected return addresses kept in exp_q
    step(SEQ_JUMP, 8'h20);
    exp_upc = 8'h20;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(exp_upc + 8'h01);
      exp_upc = 8'h30 + 8'(k * 16);
      step(SEQ_CALL, exp_upc);
      chk("nest_call", upc, exp_upc);
    end
    chk("nest_full", stk_full, 1'b1);
    chk("nest_err0", err, 1'b0);
    step(SEQ_CALL, 8'h70); chk("ovf_next", upc, exp_upc + 8'h01);
    chk("ovf_err", err, 1'b1);
    chk("ovf_full", stk_full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(SEQ_RET, 8'h00);
      chk("nest_ret", upc, exp_q.pop_back());
    end
    chk("unwind_empty", stk_empty, 1'b1);
    step(SEQ_RET, 8'h00); chk("udf_upc", upc, 8'h00);
    chk("udf_err", err, 1'b1);
    clr_err = 1'b1;
    step(SEQ_HOLD, 8'h00); chk("clr_err", err, 1'b0);
    step(SEQ_RET, 8'h00); chk("set_wins", err, 1'b1);
    clr_err = 1'b0;

    step(SEQ_JUMP, 8'h10);
    seq_op = SEQ_CALL; jump_addr = 8'h80; stall = 1'b1; clr_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("stall_upc", upc, 8'h10);
      chk("stall_empty", stk_empty, 1'b1);
      chk("stall_err", err, 1'b1);
    end
    stall = 1'b0; clr_err = 1'b0;
    step(SEQ_CALL, 8'h80); chk("post_stall_upc", upc, 8'h80);
    chk("post_stall_empty", stk_empty, 1'b0);
    chk("post_stall_err", err, 1'b1);
`else
    chk("call_empty", stk_empty, 1'b1);
    step(SEQ_RET, 8'h00); chk("ret_upc", upc, 8'h81);
    chk("ret_err", err, 1'b0);
    step(SEQ_RET, 8'h00); chk("ret2_upc", upc, 8'h82);

    step(SEQ_JUMP, 8'h10);
    seq_op = SEQ_CALL; jump_addr = 8'h80; stall = 1'b1; clr_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("stall_upc", upc, 8'h10);
    end
    stall = 1'b0; clr_err = 1'b0;
    step(SEQ_CALL, 8'h80); chk("post_stall_upc", upc, 8'h80);
    chk("nostk_err", err, 1'b0);
    chk("nostk_full", stk_full, 1'b0);
`endif

    // asynchronous reset away from any clock edge
    seq_op = SEQ_HOLD;
    #2 rst = 1'b0;
    #1;
    chk("arst_upc", upc, 8'h00);
    chk("arst_empty", stk_empty, 1'b1);
    chk("arst_full", stk_full, 1'b0);
    chk("arst_err", err, 1'b0);
    #2 rst = 1'b1;
    step(SEQ_NEXT, 8'h00); chk("after_rst_next", upc, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useq.md
USEQ -- requirements
Module: useq

Interface
REQ-001 SHALL have parameter UA_W, default 8, giving the micro-address width.
REQ-002 SHALL have parameter OP_W, default 4, giving the opcode field width; OP_W SHALL be no greater than UA_W.
REQ-003 SHALL have parameter DEPTH, default 4, giving the number of return-stack entries.
REQ-004 SHALL have parameter NCOND, default 4, giving the number of condition inputs.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; 0 clears the block.
REQ-007 SHALL have port seq_op, input, 3 bits: sequencing operation for the current microinstruction.
REQ-008 SHALL have port jump_addr, input, UA_W bits: target address for JUMP, BRT and CALL.
REQ-009 SHALL have port ir_op, input, OP_W bits: opcode field taken from the instruction register.
REQ-010 SHALL have port cond_sel, input, clog2(NCOND) bits: selects the condition tested by BRT.
REQ-011 SHALL have port cond_in, input, NCOND bits: condition flags.
REQ-012 SHALL have port stall, input, 1 bit: freezes all state while high.
REQ-013 SHALL have port clr_err, input, 1 bit: clears the sticky error flag.
REQ-014 SHALL have port upc, output, UA_W bits: registered micro-address driving the ROM address.
REQ-015 SHALL have port stk_full, output, 1 bit: asserted when the stack holds DEPTH entries.
REQ-016 SHALL have port stk_empty, output, 1 bit: asserted when the stack holds no entries.
REQ-017 SHALL have port err, output, 1 bit: sticky flag set on stack overflow or underflow.

Function
REQ-018 SHALL decode seq_op as follows: 0 NEXT, 1 JUMP, 2 MAP, 3 BRT, 4 CALL, 5 RET, 6 HOLD, 7 RESTART.
REQ-019 SHALL register every upc update, so a new address appears one clk after seq_op is presented; no combinational path from any input to upc.
REQ-020 NEXT SHALL load upc+1 modulo 2^UA_W, so all-ones wraps to 0.
REQ-021 JUMP SHALL load jump_addr.
REQ-022 MAP SHALL load {ir_op, zeros in the remaining UA_W-OP_W bits}.
REQ-023 BRT SHALL load jump_addr when cond_in[cond_sel] is 1, and upc+1 otherwise; a cond_sel value of NCOND or above SHALL count as false.
REQ-024 CALL SHALL push upc+1 (wrapped), increment the stack pointer and load jump_addr.
REQ-025 RET SHALL pop the top entry into upc and decrement the stack pointer.
REQ-026 HOLD SHALL keep upc unchanged; RESTART SHALL load 0 and empty the stack, leaving err unchanged.
REQ-027 CALL while stk_full SHALL perform no push, behave as NEXT and set err.
REQ-028 RET while stk_empty SHALL load 0 and set err.
REQ-029 When stall is 1, upc, the stack, the stack pointer and err SHALL all hold; clr_err SHALL also be ignored during a stall.
REQ-030 When clr_err is 1 in the same cycle as a new error, the set SHALL win.
REQ-031 stk_full and stk_empty SHALL be decoded from the registered stack pointer only.

Reset
REQ-032 While rst is 0, asynchronously: upc = 0, stack pointer = 0 (stk_empty = 1, stk_full = 0), err = 0.
REQ-033 Stack entry contents SHALL need no reset.
REQ-034 Reset asserted mid-CALL or mid-RET SHALL abandon the operation with no partial push or pop.

Configuration
REQ-035 Macro USEQ_STACK_EN SHALL control the return stack.
REQ-036 With USEQ_STACK_EN defined, the behaviour in REQ-024 to REQ-028 SHALL apply.
REQ-037 Without USEQ_STACK_EN: no stack storage; CALL behaves as JUMP; RET behaves as NEXT; stk_empty = 1, stk_full = 0 and err = 0 constantly.

Structure
REQ-038 A shared package SHALL hold the seq_op encoding constants (SEQ_NEXT through SEQ_RESTART) and the reset vector constant (0).
REQ-039 The return stack SHALL be one sub-module, useq_stack, with push/pop/full/empty and DEPTH and UA_W parameters; the top level holds the upc register and next-address mux.

Verification
REQ-040 Release reset, issue NEXT x3 -> upc 0,1,2,3; with upc = 8'hFF, NEXT -> 8'h00.
REQ-041 ir_op = 4'hA, MAP -> upc = 8'hA0; cond_in = 4'b0100: BRT with cond_sel 2 and jump_addr 8'h40 -> 8'h40; BRT with cond_sel 1 -> upc+1.
REQ-042 At upc = 8'h10, CALL 8'h80 -> upc 8'h80 with stk_empty = 0; then RET -> 8'h11 with stk_empty = 1.
REQ-043 Five nested CALLs with DEPTH 4 -> 5th acts as NEXT, err = 1; then four RETs return correct addresses in LIFO order; a fifth RET -> upc 0; clr_err -> err = 0.
REQ-044 stall high for 3 cycles during CALL -> no upc or stack change; clr_err issued during the stall is ignored; rst pulsed low mid-sequence -> upc 0, stk_empty 1, err 0 immediately.
REQ-045 Build without USEQ_STACK_EN: CALL 8'h80 -> upc 8'h80; RET -> upc+1; err stays 0.
